// File: rtl/rv_decode_sequencer.sv
// rv_decode_sequencer
//   Multi-cycle RV32I fetch/decode/sequence unit. Fetches over a
//   single-outstanding memory handshake, reads the register file, drives the
//   external ALU and owns the PC. Branch compares, LUI/AUIPC and link values
//   are formed here because the ALU does not produce them.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   mem_req/we/addr/wdata      memory request (held until mem_ready)
//   mem_rdata, mem_ready       memory response
//   rf_raddr1/2, rs1/rs2_data  register file read port (combinational data)
//   rf_we/waddr/wdata          register file write port
//   func3/func7/opcode/op1/op2 ALU controls and operands
//   alu_result                 ALU output (combinational)
//   pc                         current PC
//   halt                       trap indication (only with DECODE_TRAP_EN)
//
// Build option: define DECODE_TRAP_EN to trap on unsupported instructions;
// otherwise they retire as NOPs.
//
// state     | meaning
// ----------+------------------------------------------------
// FETCH     | request instruction at pc, latch IR on ready
// DECODE    | latch rs1/rs2 data and immediate
// EXECUTE   | drive ALU, resolve branches, latch ALU result
// MEM       | LW/SW data access at latched ALU result
// WRITEBACK | one-cycle rf_we, pc update (incl. JAL/JALR)
// TRAP      | halted until reset (DECODE_TRAP_EN only)
module rv_decode_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [4:0]  rf_raddr1,
  output logic [4:0]  rf_raddr2,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [2:0]  func3,
  output logic        func7,
  output logic [6:0]  opcode,
  output logic [31:0] op1,
  output logic [31:0] op2,
  input  logic [31:0] alu_result,
  output logic [31:0] pc
`ifdef DECODE_TRAP_EN
  ,
  output logic        halt
`endif
);

  localparam logic [2:0] S_FETCH   = 3'd0;
  localparam logic [2:0] S_DECODE  = 3'd1;
  localparam logic [2:0] S_EXECUTE = 3'd2;
  localparam logic [2:0] S_MEM     = 3'd3;
  localparam logic [2:0] S_WB      = 3'd4;
`ifdef DECODE_TRAP_EN
  localparam logic [2:0] S_TRAP    = 3'd5;
`endif

  logic [2:0]  state;
  logic        run;     // low until the first edge after reset release
  logic [31:0] ir, a, b, imm, alu_q, mdr;
  logic [31:0] imm_dec;
  logic        taken;

  logic [6:0] opc;
  logic [2:0] f3;
  assign opc = ir[6:0];
  assign f3  = ir[14:12];

  logic is_op, is_opimm, is_load, is_store, is_branch;
  logic is_lui, is_auipc, is_jal, is_jalr, illegal;
  assign is_op     = (opc == 7'b0110011);
  assign is_opimm  = (opc == 7'b0010011);
  assign is_load   = (opc == 7'b0000011);
  assign is_store  = (opc == 7'b0100011);
  assign is_branch = (opc == 7'b1100011);
  assign is_lui    = (opc == 7'b0110111);
  assign is_auipc  = (opc == 7'b0010111);
  assign is_jal    = (opc == 7'b1101111);
  assign is_jalr   = (opc == 7'b1100111);
  assign illegal   = !(is_op || is_opimm || is_load || is_store || is_branch ||
                       is_lui || is_auipc || is_jal || is_jalr) ||
                     ((is_load || is_store) && (f3 != 3'b010));

  always_comb begin
    imm_dec = {{20{ir[31]}}, ir[31:20]};
    if (is_store)
      imm_dec = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    else if (is_branch)
      imm_dec = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    else if (is_lui || is_auipc)
      imm_dec = {ir[31:12], 12'h000};
    else if (is_jal)
      imm_dec = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  end

  always_comb begin
    taken = 1'b0;
    case (f3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = ($signed(a) <  $signed(b));
      3'b101:  taken = ($signed(a) >= $signed(b));
      3'b110:  taken = (a <  b);
      3'b111:  taken = (a >= b);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_FETCH;
      run   <= 1'b0;
      pc    <= RESET_PC;
      ir    <= 32'h0;
      a     <= 32'h0;
      b     <= 32'h0;
      imm   <= 32'h0;
      alu_q <= 32'h0;
      mdr   <= 32'h0;
    end else begin
      run <= 1'b1;
      case (state)
        S_FETCH: begin
          if (run && mem_ready) begin
            ir    <= mem_rdata;
            state <= S_DECODE;
          end
        end
        S_DECODE: begin
          a   <= rs1_data;
          b   <= rs2_data;
          imm <= imm_dec;
          if (illegal) begin
`ifdef DECODE_TRAP_EN
            state <= S_TRAP;
`else
            pc    <= pc + 32'd4;
            state <= S_FETCH;
`endif
          end else begin
            state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          alu_q <= alu_result;
          if (is_branch) begin
            pc    <= taken ? (pc + imm) : (pc + 32'd4);
            state <= S_FETCH;
          end else if (is_load || is_store) begin
            state <= S_MEM;
          end else begin
            state <= S_WB;
          end
        end
        S_MEM: begin
          if (mem_ready) begin
            if (is_load) begin
              mdr   <= mem_rdata;
              state <= S_WB;
            end else begin
              pc    <= pc + 32'd4;
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          if (is_jal)
            pc <= pc + imm;
          else if (is_jalr)
            pc <= (a + imm) & 32'hFFFF_FFFE;
          else
            pc <= pc + 32'd4;
          state <= S_FETCH;
        end
`ifdef DECODE_TRAP_EN
        S_TRAP: state <= S_TRAP;
`endif
        default: state <= S_FETCH;
      endcase
    end
  end

  assign mem_req   = ((state == S_FETCH) && run) || (state == S_MEM);
  assign mem_we    = (state == S_MEM) && is_store;
  assign mem_addr  = (state == S_MEM) ? alu_q : pc;
  assign mem_wdata = b;

  assign rf_raddr1 = ir[19:15];
  assign rf_raddr2 = ir[24:20];
  assign rf_waddr  = ir[11:7];
  assign rf_we     = (state == S_WB) && (ir[11:7] != 5'd0);

  always_comb begin
    rf_wdata = alu_q;
    if (is_load)
      rf_wdata = mdr;
    else if (is_lui)
      rf_wdata = imm;
    else if (is_auipc)
      rf_wdata = pc + imm;
    else if (is_jal || is_jalr)
      rf_wdata = pc + 32'd4;
  end

  assign func3  = f3;
  assign opcode = opc;
  // bit 30 is an immediate bit for ordinary I-type ops; only shifts use it
  assign func7  = (is_op || (is_opimm && ((f3 == 3'b001) || (f3 == 3'b101)))) ? ir[30] : 1'b0;

  always_comb begin
    op1 = 32'h0;
    op2 = 32'h0;
    if (state == S_EXECUTE) begin
      if (is_op) begin
        op1 = a;
        op2 = b;
      end else if (is_opimm || is_load || is_store) begin
        op1 = a;
        op2 = imm;
      end
    end
  end

`ifdef DECODE_TRAP_EN
  assign halt = (state == S_TRAP);
`endif

endmodule

// File: tb/tb_rv_decode_sequencer.sv
module tb_rv_decode_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rs1_data, rs2_data;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [2:0]  func3;
  logic        func7;
  logic [6:0]  opcode;
  logic [31:0] op1, op2;
  logic [31:0] alu_result;
  logic [31:0] pc;
`ifdef DECODE_TRAP_EN
  logic        halt;
`endif

  rv_decode_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .func3(func3), .func7(func7), .opcode(opcode), .op1(op1), .op2(op2),
    .alu_result(alu_result), .pc(pc)
`ifdef DECODE_TRAP_EN
    , .halt(halt)
`endif
  );

  always #5 clk = ~clk;

  // register file contents, written only by the stimulus
  logic [31:0] regs [32];
  assign rs1_data = (rf_raddr1 == 5'd0) ? 32'h0 : regs[rf_raddr1];
  assign rs2_data = (rf_raddr2 == 5'd0) ? 32'h0 : regs[rf_raddr2];

  // reference ALU
  always_comb begin
    alu_result = 32'h0;
    if (opcode == 7'h03 || opcode == 7'h23)
      alu_result = op1 + op2;
    else
      case (func3)
        3'd0: alu_result = func7 ? (op1 - op2) : (op1 + op2);
        3'd1: alu_result = op1 << op2[4:0];
        3'd2: alu_result = {31'h0, $signed(op1) < $signed(op2)};
        3'd3: alu_result = {31'h0, op1 < op2};
        3'd4: alu_result = op1 ^ op2;
        3'd5: alu_result = func7 ? 32'($signed(op1) >>> op2[4:0]) : (op1 >> op2[4:0]);
        3'd6: alu_result = op1 | op2;
        default: alu_result = op1 & op2;
      endcase
  end

  typedef struct {
    logic [31:0] instr, a, b, ld;
    int          waits, nreq;
    logic        chk_ops;
    logic [31:0] e_op1, e_op2;
    logic        e_f7, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_wd;
    logic        e_st;
    logic [31:0] e_maddr, e_sdata, e_pc;
    int          e_cyc;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t vecs [16];
  vec_t exp_q [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic [31:0] instr, a, b, ld, input int waits, nreq,
                              input logic chk_ops, input logic [31:0] e_op1, e_op2,
                              input logic e_f7, e_we, input logic [4:0] e_rd,
                              input logic [31:0] e_wd, input logic e_st,
                              input logic [31:0] e_maddr, e_sdata, e_pc, input int e_cyc);
    vec_t v;
    v.instr = instr; v.a = a; v.b = b; v.ld = ld; v.waits = waits; v.nreq = nreq;
    v.chk_ops = chk_ops; v.e_op1 = e_op1; v.e_op2 = e_op2; v.e_f7 = e_f7;
    v.e_we = e_we; v.e_rd = e_rd; v.e_wd = e_wd; v.e_st = e_st;
    v.e_maddr = e_maddr; v.e_sdata = e_sdata; v.e_pc = e_pc; v.e_cyc = e_cyc;
    return v;
  endfunction

  // Entered at a falling edge where the instruction fetch is already visible;
  // returns at the falling edge where the next fetch request appears.
  task automatic run_vec(input int idx, input vec_t v);
    int cyc = 0, nreq = 0, wcnt = 0, fdone = -1, we_cnt = 0, hold = 0;
    logic [4:0]  w_rd = '0;
    logic [31:0] w_d = '0, s_addr = '0, s_data = '0;
    logic [31:0] o_op1 = 32'hDEAD_BEEF, o_op2 = 32'hDEAD_BEEF;
    logic        o_f7 = 1'bx, got_st = 1'b0, timed_out = 1'b1;
    vec_t e;
    regs[v.instr[24:20]] = v.b;
    regs[v.instr[19:15]] = v.a;
    exp_q.push_back(v);
    while (cyc < 64) begin
      if (mem_req && nreq == v.nreq) begin
        timed_out = 1'b0;
        break;
      end
      if (fdone >= 0 && cyc == fdone + 2) begin
        o_op1 = op1; o_op2 = op2; o_f7 = func7;
      end
      if (rf_we) begin
        we_cnt++; w_rd = rf_waddr; w_d = rf_wdata;
      end
      if (mem_req) begin
        if (nreq == 1 && mem_addr == v.e_maddr) hold++;
        if (wcnt < v.waits) begin
          mem_ready = 1'b0; wcnt++;
        end else begin
          mem_ready = 1'b1;
          mem_rdata = (nreq == 0) ? v.instr : v.ld;
          if (nreq == 0) fdone = cyc;
          if (nreq == 1) begin
            got_st = mem_we; s_addr = mem_addr; s_data = mem_wdata;
          end
          nreq++; wcnt = 0;
        end
      end else begin
        mem_ready = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    mem_ready = 1'b0;
    e = exp_q.pop_front();
    if (timed_out) begin
      chk($sformatf("v%0d_timeout", idx), 32'(cyc), 32'(e.e_cyc));
      return;
    end
    chk($sformatf("v%0d_pc", idx), pc, e.e_pc);
    chk($sformatf("v%0d_fetch_addr", idx), mem_addr, e.e_pc);
    chk($sformatf("v%0d_fetch_we", idx), {31'h0, mem_we}, 32'h0);
    if (e.e_cyc >= 0) chk($sformatf("v%0d_cycles", idx), 32'(cyc), 32'(e.e_cyc));
    chk($sformatf("v%0d_rf_we_pulses", idx), 32'(we_cnt), e.e_we ? 32'd1 : 32'd0);
    if (e.e_we) begin
      chk($sformatf("v%0d_rf_waddr", idx), {27'h0, w_rd}, {27'h0, e.e_rd});
      chk($sformatf("v%0d_rf_wdata", idx), w_d, e.e_wd);
    end
    if (e.chk_ops) begin
      chk($sformatf("v%0d_op1", idx), o_op1, e.e_op1);
      chk($sformatf("v%0d_op2", idx), o_op2, e.e_op2);
      chk($sformatf("v%0d_func7", idx), {31'h0, o_f7}, {31'h0, e.e_f7});
    end
    if (e.nreq == 2) begin
      chk($sformatf("v%0d_mem_we", idx), {31'h0, got_st}, {31'h0, e.e_st});
      chk($sformatf("v%0d_addr_hold", idx), 32'(hold), 32'(e.waits + 1));
      if (e.e_st) begin
        chk($sformatf("v%0d_st_addr", idx), s_addr, e.e_maddr);
        chk($sformatf("v%0d_st_data", idx), s_data, e.e_sdata);
      end
    end
  endtask

  initial begin
    int n;
    int seen_req;
    int seen_halt;
    for (int i = 0; i < 32; i++) regs[i] = 32'h0;
    rst_n = 1'b0;
    mem_ready = 1'b0;
    mem_rdata = 32'h0;

    //        instr         a            b            ld           w  n  ops op1          op2          f7 we rd wd           st maddr   sdata        pc      cyc
    vecs[0]  = mk(32'h00500093, 32'h0,        32'h0,        32'h0,        0, 1, 1, 32'h0,        32'h5,   0, 1, 1, 32'h5,        0, 32'h0,   32'h0,        32'h4,   4);
    vecs[1]  = mk(32'h402081B3, 32'd20,       32'd7,        32'h0,        2, 1, 1, 32'd20,       32'd7,   1, 1, 3, 32'd13,       0, 32'h0,   32'h0,        32'h8,   6);
    vecs[2]  = mk(32'h4020D213, 32'hFFFFFFF0, 32'h0,        32'h0,        0, 1, 1, 32'hFFFFFFF0, 32'h402, 1, 1, 4, 32'hFFFFFFFC, 0, 32'h0,   32'h0,        32'hC,   4);
    vecs[3]  = mk(32'h40008313, 32'h3,        32'h0,        32'h0,        0, 1, 1, 32'h3,        32'h400, 0, 1, 6, 32'h403,      0, 32'h0,   32'h0,        32'h10,  4);
    vecs[4]  = mk(32'h00208463, 32'd9,        32'd9,        32'h0,        0, 1, 0, 32'h0,        32'h0,   0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h18,  3);
    vecs[5]  = mk(32'h00209463, 32'd9,        32'd9,        32'h0,        0, 1, 0, 32'h0,        32'h0,   0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h1C,  3);
    vecs[6]  = mk(32'h0020C463, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1, 0, 32'h0,        32'h0,   0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h24,  3);
    vecs[7]  = mk(32'h0020E463, 32'hFFFFFFFF, 32'h1,        32'h0,        0, 1, 0, 32'h0,        32'h0,   0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h28,  3);
    vecs[8]  = mk(32'hFE20DCE3, 32'd5,        32'd5,        32'h0,        0, 1, 0, 32'h0,        32'h0,   0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h20,  3);
    vecs[9]  = mk(32'h0040A283, 32'h100,      32'h0,        32'hCAFEF00D, 3, 2, 1, 32'h100,      32'h4,   0, 1, 5, 32'hCAFEF00D, 0, 32'h104, 32'h0,        32'h24,  11);
    vecs[10] = mk(32'h0020A423, 32'h200,      32'h12345678, 32'h0,        1, 2, 1, 32'h200,      32'h8,   0, 0, 0, 32'h0,        1, 32'h208, 32'h12345678, 32'h28,  6);
    vecs[11] = mk(32'h000100E7, 32'h201,      32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,   0, 1, 1, 32'h2C,       0, 32'h0,   32'h0,        32'h200, 4);
    vecs[12] = mk(32'h010003EF, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,   0, 1, 7, 32'h204,      0, 32'h0,   32'h0,        32'h210, 4);
    vecs[13] = mk(32'hABCDE437, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,   0, 1, 8, 32'hABCDE000, 0, 32'h0,   32'h0,        32'h214, 4);
    vecs[14] = mk(32'h00001497, 32'h0,        32'h0,        32'h0,        0, 1, 0, 32'h0,        32'h0,   0, 1, 9, 32'h1214,     0, 32'h0,   32'h0,        32'h218, 4);
    vecs[15] = mk(32'h00100013, 32'h0,        32'h0,        32'h0,        0, 1, 1, 32'h0,        32'h1,   0, 0, 0, 32'h0,        0, 32'h0,   32'h0,        32'h21C, 4);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
    chk("rst_rf_we", {31'h0, rf_we}, 32'h0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_op1", op1, 32'h0);
    chk("rst_op2", op2, 32'h0);
    chk("rst_opcode", {25'h0, opcode}, 32'h0);
    chk("rst_mem_wdata", mem_wdata, 32'h0);
`ifdef DECODE_TRAP_EN
    chk("rst_halt", {31'h0, halt}, 32'h0);
`endif
    rst_n = 1'b1;
    #1;
    chk("release_no_req", {31'h0, mem_req}, 32'h0);
    @(negedge clk);
    chk("first_edge_req", {31'h0, mem_req}, 32'h1);

    for (int i = 0; i < 16; i++) run_vec(i, vecs[i]);
    chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

    // unsupported opcode 0x7F at pc 0x21C
    mem_ready = 1'b1;
    mem_rdata = 32'h0000007F;
    @(negedge clk);
    mem_ready = 1'b0;
`ifdef DECODE_TRAP_EN
    @(negedge clk);
    seen_req = 0; seen_halt = 0;
    for (int i = 0; i < 6; i++) begin
      if (mem_req) seen_req++;
      if (halt) seen_halt++;
      if (rf_we) seen_req++;
      @(negedge clk);
    end
    chk("trap_halt_cycles", 32'(seen_halt), 32'd6);
    chk("trap_no_activity", 32'(seen_req), 32'd0);
    chk("trap_pc_frozen", pc, 32'h21C);
`else
    n = 0;
    while (!mem_req && n < 10) begin
      if (rf_we) chk("illegal_rf_we", 32'h1, 32'h0);
      @(negedge clk);
      n++;
    end
    chk("illegal_refetch", {31'h0, mem_req}, 32'h1);
    chk("illegal_pc", pc, 32'h220);
    chk("illegal_fetch_addr", mem_addr, 32'h220);
`endif

    // reset while a load waits in MEM
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst2_fetch_req", {31'h0, mem_req}, 32'h1);
    chk("rst2_fetch_addr", mem_addr, 32'h0);
    regs[1] = 32'h300;
    regs[4] = 32'h0;
    mem_rdata = 32'h0040A283;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("mem_wait_req", {31'h0, mem_req}, 32'h1);
    chk("mem_wait_addr", mem_addr, 32'h304);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", {31'h0, mem_req}, 32'h0);
    chk("abort_pc", pc, 32'h0);
    chk("abort_rf_we", {31'h0, rf_we}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("restart_req", {31'h0, mem_req}, 32'h1);
    chk("restart_addr", mem_addr, 32'h0);
    chk("restart_we", {31'h0, mem_we}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
